// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: decode/execute hazard signals between pipeline and hazard control
interface pipe_hazard_ctrl_if;
  logic [4:0]  D_rs1, D_rs2, D_rd;
  logic        D_rs1_used, D_rs2_used;
  logic        D_reg_write, D_is_load, D_is_muldiv;
  logic        E_branch_taken, mdu_done;
  logic        stall, jb, freeze, mdu_start;
  logic [1:0]  fwd_rs1_sel, fwd_rs2_sel;
  logic [15:0] stall_cnt;
  modport master (
    output D_rs1, D_rs2, D_rd, D_rs1_used, D_rs2_used, D_reg_write, D_is_load, D_is_muldiv,
           E_branch_taken, mdu_done,
    input  stall, jb, freeze, mdu_start, fwd_rs1_sel, fwd_rs2_sel, stall_cnt
  );
  modport slave (
    input  D_rs1, D_rs2, D_rd, D_rs1_used, D_rs2_used, D_reg_write, D_is_load, D_is_muldiv,
           E_branch_taken, mdu_done,
    output stall, jb, freeze, mdu_start, fwd_rs1_sel, fwd_rs2_sel, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: forwarding selects, load-use stall, branch flush and mul/div freeze
module pipe_hazard_ctrl (
  input logic clk,
  input logic rst,
  pipe_hazard_ctrl_if.slave h
);
  typedef struct packed {
    logic [4:0] rd;
    logic       rw;
    logic       ld;
    logic       md;
  } stage_t;
  typedef enum logic {RUN, MDU_BUSY} state_t;
  state_t state, state_nx;
  stage_t e_q, m_q, w_q, d_s;
  logic stall, jb, freeze, mdu_start, load_use;
  logic [15:0] cnt;
  function automatic logic hit(stage_t s, logic [4:0] src, logic used);
    return used && s.rw && s.rd == src && s.rd != 5'd0;
  endfunction
  function automatic logic [1:0] sel(stage_t e, stage_t m, stage_t w, logic [4:0] src, logic used);
    return hit(e, src, used) ? 2'd1 : hit(m, src, used) ? 2'd2 : hit(w, src, used) ? 2'd3 : 2'd0;
  endfunction
  assign d_s = '{rd: h.D_rd, rw: h.D_reg_write, ld: h.D_is_load, md: h.D_is_muldiv};
  always_comb begin
    state_nx  = state;
    mdu_start = 1'b0;
    freeze    = 1'b0;
    if (state == RUN) begin
      mdu_start = e_q.md;
      freeze    = e_q.md;
      state_nx  = e_q.md ? MDU_BUSY : RUN;
    end else begin
      freeze    = !h.mdu_done;
      state_nx  = h.mdu_done ? RUN : MDU_BUSY;
    end
  end
  assign load_use = e_q.ld && (hit(e_q, h.D_rs1, h.D_rs1_used) || hit(e_q, h.D_rs2, h.D_rs2_used));
  assign jb    = h.E_branch_taken && !freeze;
  // flush beats load-use: the dependent instruction is being squashed anyway
  assign stall = load_use && !freeze && !jb;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      e_q   <= '0;
      m_q   <= '0;
      w_q   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (!freeze) begin
        e_q <= (stall || jb) ? '0 : d_s;
        m_q <= e_q;
        w_q <= m_q;
      end
      if ((stall || freeze) && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
    end
  end
  assign h.stall       = stall;
  assign h.jb          = jb;
  assign h.freeze      = freeze;
  assign h.mdu_start   = mdu_start;
  assign h.fwd_rs1_sel = sel(e_q, m_q, w_q, h.D_rs1, h.D_rs1_used);
  assign h.fwd_rs2_sel = sel(e_q, m_q, w_q, h.D_rs2, h.D_rs2_used);
  assign h.stall_cnt   = cnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed per-cycle vectors pushed to a scoreboard, checked by a negedge monitor
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [23:0] exp_q[$];
  string name_q[$];
  pipe_hazard_ctrl_if h();
  pipe_hazard_ctrl dut (.clk(clk), .rst(rst), .h(h));
  always #5 clk = ~clk;
  function automatic logic [23:0] ex(logic st, logic j, logic fr, logic ms, logic [1:0] s1, logic [1:0] s2, logic [15:0] c);
    return {st, j, fr, ms, s1, s2, c};
  endfunction
  task automatic cyc(input string n, input logic r, input logic [4:0] rs1, input logic u1,
                     input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                     input logic rw, input logic ld, input logic md, input logic br, input logic dn,
                     input logic [23:0] e);
    @(posedge clk);
    #1;
    rst = r;
    h.D_rs1 = rs1; h.D_rs1_used = u1; h.D_rs2 = rs2; h.D_rs2_used = u2;
    h.D_rd = rd; h.D_reg_write = rw; h.D_is_load = ld; h.D_is_muldiv = md;
    h.E_branch_taken = br; h.mdu_done = dn;
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [23:0] e, a;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = {h.stall, h.jb, h.freeze, h.mdu_start, h.fwd_rs1_sel, h.fwd_rs2_sel, h.stall_cnt};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL %s got={stall,jb,freeze,start,s1,s2,cnt}=%h want=%h", n, a, e);
      end
    end
  end
  initial begin
    h.D_rs1 = 0; h.D_rs2 = 0; h.D_rs1_used = 0; h.D_rs2_used = 0; h.D_rd = 0;
    h.D_reg_write = 0; h.D_is_load = 0; h.D_is_muldiv = 0; h.E_branch_taken = 0; h.mdu_done = 0;
    repeat (2) @(posedge clk);
    //       name         r rs1 u1 rs2 u2 rd rw ld md br dn  expected
    cyc("reset",       1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ex(0,0,0,0,0,0,0));
    cyc("idle",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ex(0,0,0,0,0,0,0));
    cyc("lu_load",     0, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, ex(0,0,0,0,0,0,0));
    cyc("lu_stall",    0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, ex(1,0,0,0,1,0,0));
    cyc("lu_fwd_m",    0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, ex(0,0,0,0,2,0,1));
    cyc("lu_after",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ex(0,0,0,0,0,0,1));
    cyc("alu_wr",      0, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, ex(0,0,0,0,0,0,1));
    cyc("fwd_e",       0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, ex(0,0,0,0,0,1,1));
    cyc("fwd_m",       0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, ex(0,0,0,0,0,2,1));
    cyc("fwd_w",       0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, ex(0,0,0,0,0,3,1));
    cyc("fwd_none",    0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, ex(0,0,0,0,0,0,1));
    cyc("x0_wr",       0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, ex(0,0,0,0,0,0,1));
    cyc("x0_rd",       0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, ex(0,0,0,0,0,0,1));
    cyc("br_load",     0, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, ex(0,0,0,0,0,0,1));
    cyc("br_flush",    0, 7, 1, 0, 0, 0, 0, 0, 0, 1, 0, ex(0,1,0,0,1,0,1));
    cyc("br_bubble",   0, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, ex(0,0,0,0,2,0,1));
    cyc("br_after",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ex(0,0,0,0,0,0,1));
    cyc("md_dec",      0, 0, 0, 0, 0, 9, 1, 0, 1, 0, 0, ex(0,0,0,0,0,0,1));
    cyc("md_start",    0, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, ex(0,0,1,1,1,0,1));
    cyc("md_busy1",    0, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, ex(0,0,1,0,1,0,2));
    cyc("md_busy_br",  0, 9, 1, 0, 0, 0, 0, 0, 0, 1, 0, ex(0,0,1,0,1,0,3));
    cyc("md_busy3",    0, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, ex(0,0,1,0,1,0,4));
    cyc("md_done",     0, 9, 1, 0, 0, 0, 0, 0, 0, 0, 1, ex(0,0,0,0,1,0,5));
    cyc("md_adv",      0, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, ex(0,0,0,0,2,0,5));
    cyc("done_in_run", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, ex(0,0,0,0,0,0,5));
    cyc("run_hold",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ex(0,0,0,0,0,0,5));
    cyc("md2_dec",     0, 0, 0, 0, 0, 10,1, 0, 1, 0, 0, ex(0,0,0,0,0,0,5));
    cyc("md2_start",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ex(0,0,1,1,0,0,5));
    cyc("md2_busy",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ex(0,0,1,0,0,0,6));
    cyc("md2_rst",     1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ex(0,0,1,0,0,0,7));
    cyc("rst_late_dn", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, ex(0,0,0,0,0,0,0));
    cyc("rst_after",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ex(0,0,0,0,0,0,0));
    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-high, ports named clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 D_rs1, D_rs2  input  5 each  decode-stage source register indices.
REQ-005 D_rs1_used, D_rs2_used  input  1 each  decode instruction reads that source.
REQ-006 D_rd  input  5  decode-stage destination index.
REQ-007 D_reg_write, D_is_load, D_is_muldiv  input  1 each  decode instruction class flags.
REQ-008 E_branch_taken  input  1  execute-stage branch/jump resolved taken.
REQ-009 mdu_done  input  1  multi-cycle mul/div unit result valid, one-cycle pulse.
REQ-010 stall  output  1  hold F/D, insert bubble into E.
REQ-011 jb  output  1  flush: bubble into E, redirect PC.
REQ-012 freeze  output  1  hold every pipeline register (F, D, E, M, W).
REQ-013 mdu_start  output  1  one-cycle start pulse to mul/div unit.
REQ-014 fwd_rs1_sel, fwd_rs2_sel  output  2 each  decode operand mux select: 0 regfile, 1 E result, 2 M result, 3 W result.
REQ-015 stall_cnt  output  16  count of stall/freeze cycles.

Function
REQ-016 Internal shadow pipeline SHALL hold {rd, reg_write, is_load, is_muldiv} for stages E, M, W.
REQ-017 When freeze=0, on each clk edge: E_shadow <= bubble (all flags 0, rd 0) if stall or jb, else D fields; M <= E; W <= M.
REQ-018 When freeze=1, all shadow registers SHALL hold.
REQ-019 Stage "hit" for a source: stage reg_write=1, stage rd==source, rd!=0, source used.
REQ-020 fwd_sel SHALL be 1 on E hit, else 2 on M hit, else 3 on W hit, else 0 (priority E>M>W); combinational.
REQ-021 Load-use: stall SHALL be 1 when E is_load=1 and E hit on either used source; otherwise 0.
REQ-022 jb SHALL equal E_branch_taken & ~freeze.
REQ-023 When jb=1, stall SHALL be forced to 0 (flush wins over load-use).
REQ-024 FSM states RUN, MDU_BUSY; reset to RUN.
REQ-025 RUN with E is_muldiv=1: mdu_start=1, freeze=1, next state MDU_BUSY.
REQ-026 MDU_BUSY: mdu_start=0; freeze=1 while mdu_done=0; in mdu_done cycle freeze=0, pipeline advances, next state RUN.
REQ-027 mdu_done in RUN SHALL be ignored.
REQ-028 While freeze=1, stall and jb SHALL be 0.
REQ-029 stall_cnt SHALL increment by 1 each cycle stall|freeze=1, saturating at 0xFFFF.

Reset
REQ-030 rst=1 at a clock edge SHALL clear all shadow stages to bubble, FSM to RUN, stall_cnt to 0, including mid-MDU_BUSY.
REQ-031 During and in the cycle after reset, stall, jb, freeze, mdu_start SHALL be 0 and fwd selects 0 unless driven by new D inputs against cleared shadows (always 0).

Verification
REQ-032 Load x5 in D, next D reads rs1=x5 -> stall=1 one cycle, then fwd_rs1_sel=2; stall_cnt=1.
REQ-033 ALU writes x3 in D, next D reads rs2=x3 -> stall=0, fwd_rs2_sel=1; a third reading x3 after one more cycle -> sel=2, then 3.
REQ-034 D reads x0 with E writing x0 -> fwd_sel=0, stall=0.
REQ-035 Load-use hazard and E_branch_taken=1 same cycle -> jb=1, stall=0; E shadow becomes bubble.
REQ-036 Muldiv enters E, mdu_done after 4 cycles -> mdu_start pulses once, freeze=1 for 4 cycles, 0 on done cycle, stall_cnt=4.
REQ-037 rst=1 during MDU_BUSY -> next cycle freeze=0, state RUN, stall_cnt=0, late mdu_done ignored.
